spc_reg_wr_arb: RTL and testbench

SPC_REG_WR_ARB -- requirements
Module: spc_reg_wr_arb

---
 rtl/spc_reg_wr_arb.sv | 200 ++++++++++++++++++++
 tb/tb_spc_reg_wr_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spc_reg_wr_arb.sv
// ---------------------------------------------------------------------------
// spc_reg_wr_arb
// Arbitrates write requests from four requesters onto the single user write
// port of the special register file. Idle cycles use round-robin priority.
// A requester that wins with its lock bit high gets exclusive ownership of
// the port (LOCKED state) until it drops lock. If it holds LOCKED for
// LOCK_MAX cycles without being served, ownership is taken away and
// lock_err pulses.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous active-high reset
//   req[3:0]       : per-requester write request
//   lock[3:0]      : per-requester atomic-sequence hold, sampled with req
//   req_addr[11:0] : 3-bit register address per requester ([3i+2:3i])
//   req_data[127:0]: 32-bit write data per requester ([32i+31:32i])
//   gnt[3:0]       : registered one-hot grant pulse
//   wr_usr_enable  : registered write strobe to the register file
//   write_usr_addr : registered write address
//   usr_data       : registered write data
//   busy           : high while the arbiter is in LOCKED
//   lock_err       : one-cycle pulse on a LOCK_MAX forced release
//
// Configuration macro
//   SPC_ARB_ZR_PROTECT_EN : when defined, writes to address 0 are still
//                           granted but the write strobe is suppressed.
// ---------------------------------------------------------------------------
module spc_reg_wr_arb #(
    parameter int LOCK_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   lock,
    input  logic [11:0]  req_addr,
    input  logic [127:0] req_data,
    output logic [3:0]   gnt,
    output logic         wr_usr_enable,
    output logic [2:0]   write_usr_addr,
    output logic [31:0]  usr_data,
    output logic         busy,
    output logic         lock_err
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic             r_state;
    logic [1:0]       r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ptr;
    logic [3:0]       r_gnt;
    logic             r_wen;
    logic [2:0]       r_addr;
    logic [31:0]      r_data;
    logic             r_lockErr;

    logic [3:0]       w_elig;
    logic [1:0]       w_cand;
    logic             w_rrValid;
    logic [1:0]       w_rrIdx;
    logic             w_win;
    logic [1:0]       w_winIdx;
    logic [2:0]       w_selAddr;
    logic [31:0]      w_selData;
    logic             w_wrAllowed;
    logic [CNT_W-1:0] w_cntInc;

    // A requester granted this cycle still has its req high when it is
    // arbitrated again, so it is masked out to avoid serving it twice.
    assign w_elig   = req & ~r_gnt;
    assign w_cntInc = r_cnt + CNT_W'(1);

    // Round-robin search starting one past the last winner and wrapping
    // back to the last winner itself, which therefore has lowest priority.
    always_comb begin
        w_rrValid = 1'b0;
        w_rrIdx   = 2'd0;
        w_cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_ptr + k[1:0];
            if (!w_rrValid && w_elig[w_cand]) begin
                w_rrValid = 1'b1;
                w_rrIdx   = w_cand;
            end
        end
    end

    // In LOCKED only the owner may be served; everyone else waits.
    always_comb begin
        w_win    = 1'b0;
        w_winIdx = 2'd0;
        if (r_state == ST_IDLE) begin
            w_win    = w_rrValid;
            w_winIdx = w_rrIdx;
        end else begin
            w_win    = w_elig[r_owner];
            w_winIdx = r_owner;
        end
    end

    // Pick out the winner's address and data slices.
    always_comb begin
        w_selAddr = req_addr[2:0];
        w_selData = req_data[31:0];
        case (w_winIdx)
            2'd0: begin
                w_selAddr = req_addr[2:0];
                w_selData = req_data[31:0];
            end
            2'd1: begin
                w_selAddr = req_addr[5:3];
                w_selData = req_data[63:32];
            end
            2'd2: begin
                w_selAddr = req_addr[8:6];
                w_selData = req_data[95:64];
            end
            default: begin
                w_selAddr = req_addr[11:9];
                w_selData = req_data[127:96];
            end
        endcase
    end

    // Address 0 is the hard-wired zero register; with protection enabled
    // the request is still granted so the requester can move on, but the
    // register file never sees a write strobe for it.
`ifdef SPC_ARB_ZR_PROTECT_EN
    assign w_wrAllowed = (w_selAddr != 3'd0);
`else
    assign w_wrAllowed = 1'b1;
`endif

    // Registered grant/write outputs plus the IDLE/LOCKED state machine.
    // Address and data only move on a grant so they hold between writes.
    // Leaving LOCKED for any reason parks the pointer on the owner so the
    // former owner goes to the back of the round-robin queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= 2'd0;
            r_cnt     <= '0;
            r_ptr     <= 2'd3;
            r_gnt     <= 4'b0000;
            r_wen     <= 1'b0;
            r_addr    <= 3'd0;
            r_data    <= 32'd0;
            r_lockErr <= 1'b0;
        end else begin
            r_gnt     <= 4'b0000;
            r_wen     <= 1'b0;
            r_lockErr <= 1'b0;
            if (w_win) begin
                r_gnt  <= 4'b0001 << w_winIdx;
                r_wen  <= w_wrAllowed;
                r_addr <= w_selAddr;
                r_data <= w_selData;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_win) begin
                        r_ptr <= w_winIdx;
                        if (lock[w_winIdx]) begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_winIdx;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    if (!lock[r_owner]) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_owner;
                        r_cnt   <= '0;
                    end else if (w_win) begin
                        r_cnt <= '0;
                    end else if (w_cntInc == CNT_W'(LOCK_MAX)) begin
                        r_state   <= ST_IDLE;
                        r_ptr     <= r_owner;
                        r_cnt     <= '0;
                        r_lockErr <= 1'b1;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
            endcase
        end
    end

    assign gnt            = r_gnt;
    assign wr_usr_enable  = r_wen;
    assign write_usr_addr = r_addr;
    assign usr_data       = r_data;
    assign busy           = (r_state == ST_LOCKED);
    assign lock_err       = r_lockErr;

endmodule

// File: tb/tb_spc_reg_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_spc_reg_wr_arb
// Directed bench for spc_reg_wr_arb. Stimulus pushes each expected grant
// (cycle, gnt, strobe, address, data) into a queue; a negedge monitor pops
// and compares whenever the arbiter shows a grant. Status outputs (busy,
// lock_err) are compared cycle by cycle as stimulus is applied.
// ---------------------------------------------------------------------------
module tb_spc_reg_wr_arb;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   lock;
    logic [11:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic         wr_usr_enable;
    logic [2:0]   write_usr_addr;
    logic [31:0]  usr_data;
    logic         busy;
    logic         lock_err;

    typedef struct {
        int          cyc;
        logic [3:0]  gnt;
        logic        wen;
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    exp_t monEntry;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    spc_reg_wr_arb #(.LOCK_MAX(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .lock           (lock),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .gnt            (gnt),
        .wr_usr_enable  (wr_usr_enable),
        .write_usr_addr (write_usr_addr),
        .usr_data       (usr_data),
        .busy           (busy),
        .lock_err       (lock_err)
    );

    always #5 clk = ~clk;

    // Cycle index used to check that each grant lands exactly one cycle
    // after the inputs that earned it.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every grant must match the oldest outstanding expectation;
    // a write strobe without a grant is always wrong.
    always @(negedge clk) begin
        if (gnt !== 4'b0000) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL grant_unexpected cyc=%0d got gnt=%b wen=%b addr=%0d data=%h, expected no grant",
                         cyc, gnt, wr_usr_enable, write_usr_addr, usr_data);
            end else begin
                monEntry = expQ.pop_front();
                if (monEntry.cyc != cyc || gnt !== monEntry.gnt || wr_usr_enable !== monEntry.wen ||
                    write_usr_addr !== monEntry.addr || usr_data !== monEntry.data) begin
                    errors++;
                    $display("[TB] FAIL grant cyc=%0d gnt=%b wen=%b addr=%0d data=%h, expected cyc=%0d gnt=%b wen=%b addr=%0d data=%h",
                             cyc, gnt, wr_usr_enable, write_usr_addr, usr_data,
                             monEntry.cyc, monEntry.gnt, monEntry.wen, monEntry.addr, monEntry.data);
                end
            end
        end else begin
            checks++;
            if (wr_usr_enable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_wen cyc=%0d got wen=%b, expected 0", cyc, wr_usr_enable);
            end
        end
    end

    // Checks the current status outputs, drives one cycle of inputs and,
    // when a grant is expected, queues it for the following cycle.
    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] l,
                                 input logic [3:0] expGnt, input logic expBusy, input logic expErr);
        exp_t e;
        int   idx;
        checks++;
        if (busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL busy cyc=%0d got %b, expected %b", cyc, busy, expBusy);
        end
        checks++;
        if (lock_err !== expErr) begin
            errors++;
            $display("[TB] FAIL lock_err cyc=%0d got %b, expected %b", cyc, lock_err, expErr);
        end
        reset = rst;
        req   = r;
        lock  = l;
        if (expGnt != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (expGnt[i]) idx = i;
            e.cyc  = cyc + 1;
            e.gnt  = expGnt;
            e.addr = req_addr[idx*3 +: 3];
            e.data = req_data[idx*32 +: 32];
`ifdef SPC_ARB_ZR_PROTECT_EN
            e.wen  = (e.addr != 3'd0);
`else
            e.wen  = 1'b1;
`endif
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Compares every output against a fully specified expected state.
    task automatic checkOutput(input string name, input logic [3:0] expGnt, input logic expWen,
                               input logic [2:0] expAddr, input logic [31:0] expData,
                               input logic expBusy, input logic expErr);
        checks += 6;
        if (gnt !== expGnt) begin
            errors++;
            $display("[TB] FAIL %s_gnt got %b, expected %b", name, gnt, expGnt);
        end
        if (wr_usr_enable !== expWen) begin
            errors++;
            $display("[TB] FAIL %s_wen got %b, expected %b", name, wr_usr_enable, expWen);
        end
        if (write_usr_addr !== expAddr) begin
            errors++;
            $display("[TB] FAIL %s_addr got %0d, expected %0d", name, write_usr_addr, expAddr);
        end
        if (usr_data !== expData) begin
            errors++;
            $display("[TB] FAIL %s_data got %h, expected %h", name, usr_data, expData);
        end
        if (busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL %s_busy got %b, expected %b", name, busy, expBusy);
        end
        if (lock_err !== expErr) begin
            errors++;
            $display("[TB] FAIL %s_lock_err got %b, expected %b", name, lock_err, expErr);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        reset    = 1'b1;
        req      = 4'b1111;
        lock     = 4'b0000;
        req_addr = 12'd0;
        req_data = 128'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 4'b0000, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);

        // Round-robin with all requesters held.
        $display("[TB] round-robin");
        req_addr = {3'd7, 3'd6, 3'd5, 3'd4};
        req_data = {32'h103, 32'h102, 32'h101, 32'h100};
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("rr_hold", 4'b0000, 1'b0, 3'd7, 32'h103, 1'b0, 1'b0);

        // Requester 2 locked for three writes while requester 0 waits.
        $display("[TB] lock sequence");
        req_addr = {3'd3, 3'd4, 3'd5, 3'd2};
        req_data = {32'h33, 32'h10, 32'h55, 32'hAAAA0000};
        applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0100, 4'b0000, 1'b1, 1'b0);
        req_data[95:64] = 32'h14;
        applyStimulus(1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0100, 4'b0000, 1'b1, 1'b0);
        req_data[95:64] = 32'h18;
        applyStimulus(1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Requester 1 locks then abandons the port: forced release.
        $display("[TB] lock timeout");
        applyStimulus(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 4'b0001, 4'b0010, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0010, 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset in the middle of a locked sequence.
        $display("[TB] reset mid-lock");
        req_addr = {3'd7, 3'd4, 3'd5, 3'd1};
        req_data = {32'h77, 32'h18, 32'h55, 32'hA0};
        applyStimulus(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b1111, 4'b1000, 4'b0000, 1'b1, 1'b0);
        checkOutput("midlock_rst", 4'b0000, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Zero-register write, then a lock request that loses first.
        $display("[TB] zero register and losing lock request");
        req_addr = {3'd0, 3'd4, 3'd3, 3'd2};
        req_data = {32'hDEADBEEF, 32'h18, 32'h30, 32'h20};
        applyStimulus(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0010, 4'b0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_grants got %0d outstanding, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
